jk_updown_counter: RTL and testbench
====================================

Name: jk_updown_counter

Overview:
- Synchronous modulo-MODULUS up/down counter whose state register is updated strictly through JK flip-flop excitation (J/K per bit), not direct D loading.
- Sits directly downstream of the single JK_FlipFlop cell: it consumes the cell's Q/Qbar behaviour as a bit-slice and builds a WIDTH-bit counting stage for the behavioural-modelling library.
- Exposes the per-bit J/K excitation vectors so benches can check them against the JK truth table (00 hold, 01 reset, 10 set, 11 toggle).

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1; legal values are 2 <= MODULUS <= 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load request.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count (registered).
- qbar  output  WIDTH  bitwise complement of q.
- j_vec  output  WIDTH  J excitation applied at the next rising edge (combinational).
- k_vec  output  WIDTH  K excitation applied at the next rising edge (combinational).
- tc  output  1  terminal count (combinational).
- wrap_pulse  output  1  registered one-cycle pulse following each wrap.

Behaviour:
- Reset: rst_n low sets q=0, qbar=all ones and wrap_pulse=0 immediately, independent of clk. The counter stays held while rst_n is low. The first update happens at the first rising edge after rst_n goes high.
- Next-state target N, with priority load > en > hold:
  - load=1: N = load_val if load_val < MODULUS, else N = MODULUS-1 (clamp).
  - en=1, up=1: N = q+1. If q == MODULUS-1, N = 0 (wrap).
  - en=1, up=0: N = q-1. If q == 0, N = MODULUS-1 (wrap).
  - Otherwise: N = q.
- Excitation per bit i:
  - j_vec[i] = ~q[i] & N[i]
  - k_vec[i] = q[i] & ~N[i]
  - No bit ever has J=K=1. Toggles are expressed as a set or a reset.
- Register update at each rising edge, per bit: q[i] <= (j_vec[i] & ~q[i]) | (~k_vec[i] & q[i]). Result: q = N one cycle after the inputs are sampled. Latency is 1 clock.
- qbar = ~q at all times, including during reset.
- tc = en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)). It is combinational and asserts in the cycle before the wrap edge.
- wrap_pulse is registered. It is 1 for exactly the cycle after an edge at which tc was 1, and 0 otherwise. A load never produces wrap_pulse.
- Simultaneous load and en: load wins, no wrap_pulse.
- Direction change mid-count takes effect at the next edge. There is no extra latency.
- Out-of-range state (q >= MODULUS) is reachable only by construction error and is not expected. If it occurs, an up count goes to 0 and a down count goes to q-1.
- Reset asserted mid-operation: q goes to 0 immediately and any pending wrap_pulse is cleared.
- j_vec and k_vec are 0 while q and the inputs imply a hold.

Test Plan:
- Reset then count up: rst_n low, then release, en=1, up=1 for 12 clocks (WIDTH=4, MODULUS=10). Required q: 0,1,...,9,0,1,2. tc=1 while q=9. wrap_pulse=1 only in the cycle where q=0 after 9.
- Count down wrap: from q=0, en=1, up=0. Required q: 9,8,7. tc=1 at q=0. wrap_pulse one cycle at q=9. At the q=0→9 step, j_vec=4'b1001 and k_vec=4'b0000.
- Excitation check: q=7 (0111), up, en. Required j_vec=4'b1000, k_vec=4'b0111, then q=8. Never j_vec[i]&k_vec[i]=1 over the whole run (assertion).
- Load priority and clamp: load=1, en=1, load_val=5 gives q=5 and no wrap_pulse. load_val=13 gives q=9. load at q=9 with up=1, en=1, load_val=3 gives q=3, tc=0, wrap_pulse=0.
- Hold and qbar: en=0, load=0 for 5 clocks at q=6. Required q stays 6, qbar=4'b1001, j_vec=k_vec=0.
- Async reset mid-count: assert rst_n low between edges while q=4 and en=1. Required q=0, qbar=4'b1111 and wrap_pulse=0 without waiting for clk. Counting resumes 0,1,... after release.

Source files
------------

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose state moves only through per-bit JK excitation.
// Latency 1 clk (q follows next-state target); no backpressure, inputs are sampled every edge.
module jk_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap_pulse
);

  // One extra bit so MODULUS == 2^WIDTH still compares correctly against load_val.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (q == MAX_CNT);
  assign at_zero = (q == '0);

  always_comb begin
    nxt = q;
    if (load) begin
      nxt = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_CNT;
    end else if (en) begin
      // Up from any state at or above the top (including illegal ones) wraps to 0.
      if (up) nxt = (q >= MAX_CNT) ? '0 : q + 1'b1;
      else    nxt = at_zero ? MAX_CNT : q - 1'b1;
    end
  end

  // Toggles are split into a set or a reset, so J and K are never both high.
  assign j_vec = ~q & nxt;
  assign k_vec = q & ~nxt;
  assign qbar  = ~q;
  assign tc    = en & ~load & ((up & at_max) | (~up & at_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      q          <= (j_vec & ~q) | (~k_vec & q);
      wrap_pulse <= tc;
    end
  end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Scoreboard bench for jk_updown_counter (WIDTH=4, MODULUS=10) with hand-computed vectors.
module tb_jk_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [3:0] qbar;
  logic [3:0] j_vec;
  logic [3:0] k_vec;
  logic       tc;
  logic       wrap_pulse;

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
    .q          (q),
    .qbar       (qbar),
    .j_vec      (j_vec),
    .k_vec      (k_vec),
    .tc         (tc),
    .wrap_pulse (wrap_pulse)
  );

  // Falling edges land between a vector being driven and the edge it targets.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] q;
    logic [3:0] j;
    logic [3:0] k;
    logic       tc;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vcount = 0;

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %b, required %b", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show before the coming edge.
  task automatic vec(input logic e, input logic u, input logic l, input logic [3:0] lv,
                     input logic [3:0] eq, input logic [3:0] ej, input logic [3:0] ek,
                     input logic etc, input logic ew);
    exp_t x;
    en = e; up = u; load = l; load_val = lv;
    x.idx = vcount; x.q = eq; x.j = ej; x.k = ek; x.tc = etc; x.wrap = ew;
    sb.push_back(x);
    vcount++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("q",     x.idx, q,                x.q);
      chk("qbar",  x.idx, qbar,             ~x.q);
      chk("j_vec", x.idx, j_vec,            x.j);
      chk("k_vec", x.idx, k_vec,            x.k);
      chk("tc",    x.idx, {3'b000, tc},     {3'b000, x.tc});
      chk("wrap",  x.idx, {3'b000, wrap_pulse}, {3'b000, x.wrap});
    end
  end

  // J=K=1 must never appear on any bit.
  always @(negedge clk) begin
    checks++;
    if ((j_vec & k_vec) != 4'b0000) begin
      errors++;
      $display("FAIL jk_exclusive: j_vec=%b k_vec=%b, required no common bit", j_vec, k_vec);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;
    #1;
    // reset state
    vec(0,0,0,4'd0, 4'd0, 4'b0000, 4'b0000, 0, 0);
    rst_n = 1'b1;

    // count up 0..9,0,1
    vec(1,1,0,4'd0, 4'd0, 4'b0001, 4'b0000, 0, 0);
    vec(1,1,0,4'd0, 4'd1, 4'b0010, 4'b0001, 0, 0);
    vec(1,1,0,4'd0, 4'd2, 4'b0001, 4'b0000, 0, 0);
    vec(1,1,0,4'd0, 4'd3, 4'b0100, 4'b0011, 0, 0);
    vec(1,1,0,4'd0, 4'd4, 4'b0001, 4'b0000, 0, 0);
    vec(1,1,0,4'd0, 4'd5, 4'b0010, 4'b0001, 0, 0);
    vec(1,1,0,4'd0, 4'd6, 4'b0001, 4'b0000, 0, 0);
    vec(1,1,0,4'd0, 4'd7, 4'b1000, 4'b0111, 0, 0);
    vec(1,1,0,4'd0, 4'd8, 4'b0001, 4'b0000, 0, 0);
    vec(1,1,0,4'd0, 4'd9, 4'b0000, 4'b1001, 1, 0);
    vec(1,1,0,4'd0, 4'd0, 4'b0001, 4'b0000, 0, 1);
    vec(1,1,0,4'd0, 4'd1, 4'b0010, 4'b0001, 0, 0);

    // direction change at q=2, down through the 0 -> 9 wrap
    vec(1,0,0,4'd0, 4'd2, 4'b0001, 4'b0010, 0, 0);
    vec(1,0,0,4'd0, 4'd1, 4'b0000, 4'b0001, 0, 0);
    vec(1,0,0,4'd0, 4'd0, 4'b1001, 4'b0000, 1, 0);
    vec(1,0,0,4'd0, 4'd9, 4'b0000, 4'b0001, 0, 1);
    vec(1,0,0,4'd0, 4'd8, 4'b0111, 4'b1000, 0, 0);

    // excitation at q=7 counting up
    vec(1,1,0,4'd0, 4'd7, 4'b1000, 4'b0111, 0, 0);

    // load priority and clamp
    vec(1,1,1,4'd5,  4'd8, 4'b0101, 4'b1000, 0, 0);
    vec(1,1,1,4'd13, 4'd5, 4'b1000, 4'b0100, 0, 0);
    vec(1,1,1,4'd3,  4'd9, 4'b0010, 4'b1000, 0, 0);
    vec(0,1,1,4'd6,  4'd3, 4'b0100, 4'b0001, 0, 0);

    // hold at 6
    vec(0,1,0,4'd0, 4'd6, 4'b0000, 4'b0000, 0, 0);
    vec(0,0,0,4'd0, 4'd6, 4'b0000, 4'b0000, 0, 0);
    vec(0,1,0,4'd0, 4'd6, 4'b0000, 4'b0000, 0, 0);
    vec(0,0,0,4'd0, 4'd6, 4'b0000, 4'b0000, 0, 0);
    vec(0,1,0,4'd0, 4'd6, 4'b0000, 4'b0000, 0, 0);
    vec(0,0,1,4'd4, 4'd6, 4'b0000, 4'b0010, 0, 0);

    // async reset between edges while counting from 4
    en = 1'b1; up = 1'b1; load = 1'b0;
    #2;
    chk("q_pre_reset", vcount, q, 4'd4);
    rst_n = 1'b0;
    #1;
    chk("q_async_reset",    vcount, q,    4'd0);
    chk("qbar_async_reset", vcount, qbar, 4'b1111);
    chk("wrap_async_reset", vcount, {3'b000, wrap_pulse}, 4'b0000);
    // held through an edge while reset stays low
    vec(1,1,0,4'd0, 4'd0, 4'b0001, 4'b0000, 0, 0);
    rst_n = 1'b1;
    vec(1,1,0,4'd0, 4'd0, 4'b0001, 4'b0000, 0, 0);
    vec(1,1,0,4'd0, 4'd1, 4'b0010, 4'b0001, 0, 0);
    vec(0,1,0,4'd0, 4'd2, 4'b0000, 4'b0000, 0, 0);

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
